bus_interface_fsm: RTL and testbench

- Parametrised successor to the host bus interface; sits between the async host bus and the register file.
- Synchronises the bus, glitch-filters chip select, and issues one-cycle read/write strobes.
- Waits for a register-side acknowledge, with timeout, then drives DTACK and read data back.
- Generalises the fixed-width, single-path bus port to configurable width, sync depth and CS qualification, and adds a read-data return path.

---
 rtl/bus_interface_fsm.sv | 231 +++++++++++++++++++++++
 tb/tb_bus_interface_fsm.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_interface_fsm.sv
// Host bus to register-file bridge: synchronises the async bus, qualifies chip select,
// issues one-cycle read/write strobes and returns DTACK/read data with an ack timeout.
module bus_interface_fsm #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned REG_BITS    = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned CS_DELAY    = 1,
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter int unsigned DTACK_EN    = 1
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic                  bus_cs_n_i,
  input  logic                  bus_rd_nwr_i,
  input  logic [REG_BITS-1:0]   bus_reg_num_i,
  input  logic                  bus_bytesel_i,
  input  logic [DATA_WIDTH-1:0] bus_data_i,
  output logic [DATA_WIDTH-1:0] bus_data_o,
  output logic                  bus_data_oe_o,
  output logic                  bus_dtack_o,
  output logic                  write_strobe_o,
  output logic                  read_strobe_o,
  output logic [REG_BITS-1:0]   reg_num_o,
  output logic                  bytesel_o,
  output logic [DATA_WIDTH-1:0] bytedata_o,
  input  logic                  reg_ack_i,
  input  logic [DATA_WIDTH-1:0] reg_rd_data_i,
  output logic                  timeout_o,
  output logic                  busy_o
);

  localparam int unsigned CS_STAGES = SYNC_STAGES + 1;
  localparam int unsigned QCNT_W    = 4;
  localparam int unsigned TCNT_W    = 8;
  localparam logic [QCNT_W-1:0] QUAL_LAST = QCNT_W'((CS_DELAY == 0) ? 0 : CS_DELAY - 1);
  localparam logic [TCNT_W-1:0] TMO_LAST  = TCNT_W'(ACK_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_QUALIFY = 3'd1;
  localparam logic [2:0] S_STROBE  = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_ACK     = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;

  logic [CS_STAGES-1:0]   r_cs_sync;
  logic [CS_STAGES-1:0]   r_cs_vld;
  logic [SYNC_STAGES-1:0] r_rd_sync;
  logic [SYNC_STAGES-1:0] r_bs_sync;
  logic [REG_BITS-1:0]    r_reg_sync  [SYNC_STAGES];
  logic [DATA_WIDTH-1:0]  r_data_sync [SYNC_STAGES];

  logic w_cs_ff0, w_cs_s, w_cs_s_vld;
  assign w_cs_ff0   = r_cs_sync[0];
  assign w_cs_s     = r_cs_sync[CS_STAGES-1];
  assign w_cs_s_vld = r_cs_vld[CS_STAGES-1];

  // The valid chain keeps reset-loaded 1s in the CS chain from arming an access.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_cs_sync <= '1;
      r_cs_vld  <= '0;
      r_rd_sync <= '0;
      r_bs_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_reg_sync[i]  <= '0;
        r_data_sync[i] <= '0;
      end
    end else begin
      r_cs_sync      <= {r_cs_sync[CS_STAGES-2:0], bus_cs_n_i};
      r_cs_vld       <= {r_cs_vld[CS_STAGES-2:0], 1'b1};
      r_rd_sync      <= {r_rd_sync[SYNC_STAGES-2:0], bus_rd_nwr_i};
      r_bs_sync      <= {r_bs_sync[SYNC_STAGES-2:0], bus_bytesel_i};
      r_reg_sync[0]  <= bus_reg_num_i;
      r_data_sync[0] <= bus_data_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_reg_sync[i]  <= r_reg_sync[i-1];
        r_data_sync[i] <= r_data_sync[i-1];
      end
    end
  end

  logic [2:0]            r_state, w_state_nxt;
  logic [QCNT_W-1:0]     r_qcnt, w_qcnt_nxt;
  logic [TCNT_W-1:0]     r_tcnt, w_tcnt_nxt;
  logic                  r_armed, w_armed_nxt;
  logic                  r_is_read, w_is_read_nxt;
  logic                  r_wstb, w_wstb_nxt;
  logic                  r_rstb, w_rstb_nxt;
  logic [REG_BITS-1:0]   r_reg_num, w_reg_num_nxt;
  logic                  r_bytesel, w_bytesel_nxt;
  logic [DATA_WIDTH-1:0] r_bytedata, w_bytedata_nxt;
  logic                  r_dtack, w_dtack_nxt;
  logic                  r_oe, w_oe_nxt;
  logic [DATA_WIDTH-1:0] r_bus_data, w_bus_data_nxt;
  logic                  r_timeout, w_timeout_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  w_enter_strobe;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_state    <= S_IDLE;
      r_qcnt     <= '0;
      r_tcnt     <= '0;
      r_armed    <= 1'b0;
      r_is_read  <= 1'b0;
      r_wstb     <= 1'b0;
      r_rstb     <= 1'b0;
      r_reg_num  <= '0;
      r_bytesel  <= 1'b0;
      r_bytedata <= '0;
      r_dtack    <= 1'b1;
      r_oe       <= 1'b0;
      r_bus_data <= '0;
      r_timeout  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_qcnt     <= w_qcnt_nxt;
      r_tcnt     <= w_tcnt_nxt;
      r_armed    <= w_armed_nxt;
      r_is_read  <= w_is_read_nxt;
      r_wstb     <= w_wstb_nxt;
      r_rstb     <= w_rstb_nxt;
      r_reg_num  <= w_reg_num_nxt;
      r_bytesel  <= w_bytesel_nxt;
      r_bytedata <= w_bytedata_nxt;
      r_dtack    <= w_dtack_nxt;
      r_oe       <= w_oe_nxt;
      r_bus_data <= w_bus_data_nxt;
      r_timeout  <= w_timeout_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    w_state_nxt    = r_state;
    w_qcnt_nxt     = r_qcnt;
    w_tcnt_nxt     = r_tcnt;
    w_armed_nxt    = r_armed;
    w_is_read_nxt  = r_is_read;
    w_wstb_nxt     = 1'b0;
    w_rstb_nxt     = 1'b0;
    w_reg_num_nxt  = r_reg_num;
    w_bytesel_nxt  = r_bytesel;
    w_bytedata_nxt = r_bytedata;
    w_dtack_nxt    = r_dtack;
    w_oe_nxt       = r_oe;
    w_bus_data_nxt = r_bus_data;
    w_timeout_nxt  = 1'b0;
    w_enter_strobe = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_cs_s_vld && w_cs_s) w_armed_nxt = 1'b1;
        if (!w_cs_s && r_armed) begin
          if (CS_DELAY == 0) begin
            w_enter_strobe = 1'b1;
          end else begin
            w_state_nxt = S_QUALIFY;
            w_qcnt_nxt  = '0;
          end
        end
      end
      S_QUALIFY: begin
        if (w_cs_s)                 w_state_nxt = S_IDLE;
        else if (r_qcnt == QUAL_LAST) w_enter_strobe = 1'b1;
        else                        w_qcnt_nxt = r_qcnt + 1'b1;
      end
      S_STROBE: begin
        w_state_nxt = S_WAIT;
        w_tcnt_nxt  = '0;
      end
      S_WAIT: begin
        if (w_cs_ff0) begin
          w_state_nxt = S_IDLE;
        end else if (reg_ack_i) begin
          w_state_nxt = S_ACK;
          if (r_is_read) w_bus_data_nxt = reg_rd_data_i;
        end else if (r_tcnt == TMO_LAST) begin
          w_state_nxt   = S_ACK;
          w_timeout_nxt = 1'b1;
          if (r_is_read) w_bus_data_nxt = '1;
        end else begin
          w_tcnt_nxt = r_tcnt + 1'b1;
        end
      end
      S_ACK: begin
        w_dtack_nxt = (DTACK_EN == 0);
        w_oe_nxt    = r_is_read;
        w_state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (w_cs_ff0) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_enter_strobe) begin
      w_state_nxt    = S_STROBE;
      w_is_read_nxt  = r_rd_sync[SYNC_STAGES-1];
      w_rstb_nxt     = r_rd_sync[SYNC_STAGES-1];
      w_wstb_nxt     = !r_rd_sync[SYNC_STAGES-1];
      w_reg_num_nxt  = r_reg_sync[SYNC_STAGES-1];
      w_bytesel_nxt  = r_bs_sync[SYNC_STAGES-1];
      w_bytedata_nxt = r_data_sync[SYNC_STAGES-1];
    end

    // Bus release always wins: withdraw DTACK/oe and abandon an unfinished ack.
    if (w_cs_ff0) begin
      w_dtack_nxt = 1'b1;
      w_oe_nxt    = 1'b0;
      if (r_state == S_ACK) w_state_nxt = S_IDLE;
    end

    if (w_state_nxt != S_IDLE) w_armed_nxt = 1'b0;
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign bus_data_o     = r_bus_data;
  assign bus_data_oe_o  = r_oe;
  assign bus_dtack_o    = r_dtack;
  assign write_strobe_o = r_wstb;
  assign read_strobe_o  = r_rstb;
  assign reg_num_o      = r_reg_num;
  assign bytesel_o      = r_bytesel;
  assign bytedata_o     = r_bytedata;
  assign timeout_o      = r_timeout;
  assign busy_o         = r_busy;

endmodule

// File: tb/tb_bus_interface_fsm.sv
// Directed bench for bus_interface_fsm: default instance plus a wide, CS_DELAY=0 instance.
module tb_bus_interface_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_i;
  int   checks   = 0;
  int   failures = 0;
  int   strobes;

  // Default-parameter instance
  logic       cs0_n, rd0, bs0, ack0;
  logic [3:0] reg0;
  logic [7:0] din0, rdd0;
  logic [7:0] d0_data, d0_bytedata;
  logic [3:0] d0_reg_num;
  logic       d0_oe, d0_dtack, d0_wstb, d0_rstb, d0_bs, d0_tmo, d0_busy;

  bus_interface_fsm dut0 (
    .clk(clk), .reset_i(reset_i), .bus_cs_n_i(cs0_n), .bus_rd_nwr_i(rd0),
    .bus_reg_num_i(reg0), .bus_bytesel_i(bs0), .bus_data_i(din0),
    .bus_data_o(d0_data), .bus_data_oe_o(d0_oe), .bus_dtack_o(d0_dtack),
    .write_strobe_o(d0_wstb), .read_strobe_o(d0_rstb), .reg_num_o(d0_reg_num),
    .bytesel_o(d0_bs), .bytedata_o(d0_bytedata), .reg_ack_i(ack0),
    .reg_rd_data_i(rdd0), .timeout_o(d0_tmo), .busy_o(d0_busy)
  );

  // Wide instance with no extra CS qualification
  logic        cs1_n, rd1, bs1, ack1;
  logic [5:0]  reg1;
  logic [15:0] din1, rdd1;
  logic [15:0] d1_data, d1_bytedata;
  logic [5:0]  d1_reg_num;
  logic        d1_oe, d1_dtack, d1_wstb, d1_rstb, d1_bs, d1_tmo, d1_busy;

  bus_interface_fsm #(.REG_BITS(6), .DATA_WIDTH(16), .CS_DELAY(0)) dut1 (
    .clk(clk), .reset_i(reset_i), .bus_cs_n_i(cs1_n), .bus_rd_nwr_i(rd1),
    .bus_reg_num_i(reg1), .bus_bytesel_i(bs1), .bus_data_i(din1),
    .bus_data_o(d1_data), .bus_data_oe_o(d1_oe), .bus_dtack_o(d1_dtack),
    .write_strobe_o(d1_wstb), .read_strobe_o(d1_rstb), .reg_num_o(d1_reg_num),
    .bytesel_o(d1_bs), .bytedata_o(d1_bytedata), .reg_ack_i(ack1),
    .reg_rd_data_i(rdd1), .timeout_o(d1_tmo), .busy_o(d1_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_i = 1'b1;
    cs0_n = 1'b1; rd0 = 1'b0; bs0 = 1'b0; ack0 = 1'b0; reg0 = '0; din0 = '0; rdd0 = '0;
    cs1_n = 1'b1; rd1 = 1'b0; bs1 = 1'b0; ack1 = 1'b0; reg1 = '0; din1 = '0; rdd1 = '0;
    tick(); tick(); tick();
    chk("rst_dtack", 32'(d0_dtack), 32'd1);
    chk("rst_wstb", 32'(d0_wstb), 32'd0);
    chk("rst_rstb", 32'(d0_rstb), 32'd0);
    chk("rst_busy", 32'(d0_busy), 32'd0);
    chk("rst_oe", 32'(d0_oe), 32'd0);
    chk("rst_data", 32'(d0_data), 32'd0);
    chk("rst_tmo", 32'(d0_tmo), 32'd0);
    chk("rst_dtack1", 32'(d1_dtack), 32'd1);
    reset_i = 1'b0;
    repeat (6) tick();

    // Write reg 5 / 0xA7: strobe at edge 5, ack sampled at edge 7, DTACK at edge 8
    rd0 = 1'b0; reg0 = 4'h5; din0 = 8'hA7; cs0_n = 1'b0;
    repeat (3) tick();
    chk("wr_e3_stb", 32'(d0_wstb), 32'd0);
    tick();
    chk("wr_e4_stb", 32'(d0_wstb), 32'd0);
    chk("wr_e4_busy", 32'(d0_busy), 32'd1);
    tick();
    chk("wr_e5_wstb", 32'(d0_wstb), 32'd1);
    chk("wr_e5_rstb", 32'(d0_rstb), 32'd0);
    chk("wr_e5_reg", 32'(d0_reg_num), 32'h5);
    chk("wr_e5_data", 32'(d0_bytedata), 32'hA7);
    tick();
    chk("wr_e6_wstb", 32'(d0_wstb), 32'd0);
    ack0 = 1'b1;
    tick();
    chk("wr_e7_dtack", 32'(d0_dtack), 32'd1);
    ack0 = 1'b0;
    tick();
    chk("wr_e8_dtack", 32'(d0_dtack), 32'd0);
    chk("wr_e8_oe", 32'(d0_oe), 32'd0);
    repeat (4) tick();
    chk("wr_e12_dtack", 32'(d0_dtack), 32'd0);
    cs0_n = 1'b1;
    tick();
    chk("wr_rel1_dtack", 32'(d0_dtack), 32'd0);
    tick();
    chk("wr_rel2_dtack", 32'(d0_dtack), 32'd1);
    chk("wr_rel2_busy", 32'(d0_busy), 32'd0);
    repeat (4) tick();

    // Read reg 3: ack held over the STROBE cycle, accepted at edge 7
    rd0 = 1'b1; reg0 = 4'h3; rdd0 = 8'h3C; cs0_n = 1'b0;
    repeat (5) tick();
    chk("rd_e5_rstb", 32'(d0_rstb), 32'd1);
    chk("rd_e5_wstb", 32'(d0_wstb), 32'd0);
    chk("rd_e5_reg", 32'(d0_reg_num), 32'h3);
    ack0 = 1'b1;
    tick();
    tick();
    chk("rd_e7_data", 32'(d0_data), 32'h3C);
    chk("rd_e7_oe", 32'(d0_oe), 32'd0);
    ack0 = 1'b0; rdd0 = 8'h00;
    tick();
    chk("rd_e8_oe", 32'(d0_oe), 32'd1);
    chk("rd_e8_dtack", 32'(d0_dtack), 32'd0);
    chk("rd_e8_data", 32'(d0_data), 32'h3C);
    tick();
    cs0_n = 1'b1;
    tick();
    chk("rd_ff0_oe", 32'(d0_oe), 32'd1);
    tick();
    chk("rd_drop_oe", 32'(d0_oe), 32'd0);
    chk("rd_drop_dtack", 32'(d0_dtack), 32'd1);
    repeat (4) tick();

    // One-clock CS glitch: reaches QUALIFY, then rejected
    rd0 = 1'b0; cs0_n = 1'b0;
    tick();
    cs0_n = 1'b1;
    repeat (3) tick();
    chk("gl_e4_busy", 32'(d0_busy), 32'd1);
    tick();
    chk("gl_e5_wstb", 32'(d0_wstb), 32'd0);
    chk("gl_e5_busy", 32'(d0_busy), 32'd0);
    tick();
    chk("gl_e6_busy", 32'(d0_busy), 32'd0);
    repeat (4) tick();

    // Read timeout; an ack only during STROBE must be ignored
    rd0 = 1'b1; reg0 = 4'h9; rdd0 = 8'h55; cs0_n = 1'b0;
    repeat (5) tick();
    chk("to_e5_rstb", 32'(d0_rstb), 32'd1);
    ack0 = 1'b1;
    tick();
    ack0 = 1'b0;
    for (int e = 7; e <= 20; e++) begin
      tick();
      chk("to_early_tmo", 32'(d0_tmo), 32'd0);
    end
    tick();
    chk("to_e21_tmo", 32'(d0_tmo), 32'd1);
    chk("to_e21_data", 32'(d0_data), 32'hFF);
    tick();
    chk("to_e22_tmo", 32'(d0_tmo), 32'd0);
    chk("to_e22_dtack", 32'(d0_dtack), 32'd0);
    chk("to_e22_oe", 32'(d0_oe), 32'd1);
    cs0_n = 1'b1;
    repeat (6) tick();
    chk("to_end_dtack", 32'(d0_dtack), 32'd1);
    chk("to_end_oe", 32'(d0_oe), 32'd0);

    // CS released in WAIT: abort, late ack gives no DTACK
    rd0 = 1'b0; reg0 = 4'h2; din0 = 8'h11; cs0_n = 1'b0;
    repeat (5) tick();
    chk("ab_e5_wstb", 32'(d0_wstb), 32'd1);
    tick();
    cs0_n = 1'b1;
    tick();
    chk("ab_e7_busy", 32'(d0_busy), 32'd1);
    tick();
    chk("ab_e8_busy", 32'(d0_busy), 32'd0);
    ack0 = 1'b1;
    tick();
    chk("ab_e9_dtack", 32'(d0_dtack), 32'd1);
    ack0 = 1'b0;
    repeat (3) tick();
    chk("ab_late_dtack", 32'(d0_dtack), 32'd1);
    chk("ab_late_busy", 32'(d0_busy), 32'd0);
    chk("ab_hold_data", 32'(d0_bytedata), 32'h11);

    // CS held low through reset: nothing until CS goes high then low again
    reset_i = 1'b1; cs0_n = 1'b0;
    repeat (3) tick();
    reset_i = 1'b0;
    strobes = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      strobes += int'(d0_wstb) + int'(d0_rstb);
    end
    chk("rs_no_strobe", 32'(strobes), 32'd0);
    chk("rs_busy", 32'(d0_busy), 32'd0);
    cs0_n = 1'b1;
    repeat (5) tick();
    cs0_n = 1'b0;
    strobes = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      strobes += int'(d0_wstb) + int'(d0_rstb);
    end
    chk("rs_one_strobe", 32'(strobes), 32'd1);
    cs0_n = 1'b1;
    repeat (6) tick();

    // Wide instance, CS_DELAY=0: 4-clock CS pulse strobes at edge 4
    rd1 = 1'b0; reg1 = 6'h2A; din1 = 16'hBEEF; bs1 = 1'b1; cs1_n = 1'b0;
    repeat (3) tick();
    chk("wd_e3_wstb", 32'(d1_wstb), 32'd0);
    tick();
    chk("wd_e4_wstb", 32'(d1_wstb), 32'd1);
    chk("wd_e4_reg", 32'(d1_reg_num), 32'h2A);
    chk("wd_e4_data", 32'(d1_bytedata), 32'hBEEF);
    chk("wd_e4_bs", 32'(d1_bs), 32'd1);
    cs1_n = 1'b1;
    tick();
    tick();
    chk("wd_e6_busy", 32'(d1_busy), 32'd0);
    chk("wd_e6_reg", 32'(d1_reg_num), 32'h2A);
    chk("wd_e6_dtack", 32'(d1_dtack), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
